// File: rtl/f_predict_pkg.sv
// f_predict_pkg: shared widths, entry layout, counter and FSM encodings for the fetch-side predictor.
package f_predict_pkg;
  localparam int PC_W    = 13;
  localparam int IDX_W   = 11;
  localparam int TAG_W   = 2;
  localparam int ENTRY_W = 18;
  localparam int DEPTH   = 2 ** IDX_W;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  typedef enum logic [1:0] {INIT, DRAIN, RUN} fsm_e;
  // Packed so that valid=17, state=16:15, tag=14:13, target=12:0.
  typedef struct packed {
    logic             valid;
    logic [1:0]       state;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } entry_t;
endpackage

// File: rtl/f_predict_btb_ram.sv
// btb_ram: 2048x18 prediction cache, one write port and one synchronous read port.
// Optional BTB_BYPASS_EN makes a same-index read return the entry being written.
module btb_ram
  import f_predict_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   w_addr,
  input  logic [ENTRY_W-1:0] w_data,
  input  logic [IDX_W-1:0]   r_addr,
  output logic [ENTRY_W-1:0] r_data
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
`ifdef BTB_BYPASS_EN
    r_data <= (we && w_addr == r_addr) ? w_data : mem[r_addr];
`else
    r_data <= mem[r_addr];
`endif
  end
endmodule

// File: rtl/f_predict.sv
// f_predict: fetch PC register, prediction cache read and hit logic; clears the cache after reset.
// Optional BTB_BYPASS_EN (in btb_ram) selects write-first behaviour on read/write collisions.
module f_predict
  import f_predict_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 13'd0,
  parameter logic [1:0]      TAKEN_MIN = 2'b10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               fail_predict,
  input  logic [PC_W-1:0]    true_pc,
  input  logic               wen,
  input  logic [IDX_W-1:0]   w_addr,
  input  logic [ENTRY_W-1:0] w_data,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_predicted,
  output logic [1:0]         state,
  output logic               pred_hit,
  output logic               fetch_valid
);
  fsm_e               fsm;
  logic [IDX_W-1:0]   cnt;
  logic [PC_W-1:0]    n_pc;
  logic [ENTRY_W-1:0] r_data;
  logic               run, clearing, tag_match, ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [ENTRY_W-1:0] ram_wdata;
  entry_t             e;
  assign run       = fsm == RUN;
  assign clearing  = fsm == INIT;
  assign e         = entry_t'(r_data);
  assign tag_match = run & e.valid & (e.tag == pc[PC_W-1:IDX_W]);
  assign pred_hit  = tag_match & (e.state >= TAKEN_MIN);
  assign pc_predicted = pred_hit ? e.target : pc + 13'd1;
  assign state     = tag_match ? e.state : WNT;
  // The read index follows n_pc so the entry for pc lands in the same cycle as pc.
  assign n_pc = (rst | !run) ? RESET_PC : fail_predict ? true_pc : stall ? pc : pc_predicted;
  assign ram_we    = !rst & (clearing | (run & wen));
  assign ram_waddr = clearing ? cnt : w_addr;
  assign ram_wdata = clearing ? '0 : w_data;
  btb_ram u_ram (
    .clk    (clk),
    .we     (ram_we),
    .w_addr (ram_waddr),
    .w_data (ram_wdata),
    .r_addr (n_pc[IDX_W-1:0]),
    .r_data (r_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= INIT;
      cnt         <= '0;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      cnt         <= clearing ? cnt + 1'b1 : cnt;
      fsm         <= clearing ? (&cnt ? DRAIN : INIT) : (fsm == DRAIN ? RUN : fsm);
      fetch_valid <= (fsm == DRAIN) | run;
      pc          <= run ? n_pc : RESET_PC;
    end
  end
endmodule
